bp_be_late_wb_arbiter: RTL and testbench

Writeback end of the backend register scoreboard. It collects late writebacks (rd, data) from several long-latency producers such as the divider, FPU and non-blocking load return. It arbitrates them round-robin into a small FIFO, then drains one entry per cycle to the register file write port. Each drained entry also produces the matching scoreboard clear, so the RF write and the scoreboard clear land on the same clock edge.

---
 rtl/bp_be_late_wb_arbiter.sv | 116 +++++++++++
 tb/tb_bp_be_late_wb_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/bp_be_late_wb_arbiter.sv
// Late writeback arbiter: round-robin collects {rd, data} from long-latency producers
// into a small FIFO and drains one entry per cycle to the RF port with a matching scoreboard clear.
module bp_be_late_wb_arbiter #(
   parameter int num_src_p        = 2,
   parameter int data_width_p     = 64,
   parameter int reg_addr_width_p = 5,
   parameter int fifo_els_p       = 4
) (
   input  logic                                  clk_i,
   input  logic                                  reset_n_i,
   input  logic [num_src_p-1:0]                  src_v_i,
   input  logic [num_src_p*reg_addr_width_p-1:0] src_rd_i,
   input  logic [num_src_p*data_width_p-1:0]     src_data_i,
   output logic [num_src_p-1:0]                  src_yumi_o,
   output logic                                  wb_v_o,
   output logic [reg_addr_width_p-1:0]           wb_rd_o,
   output logic [data_width_p-1:0]               wb_data_o,
   input  logic                                  wb_ready_and_i,
   output logic                                  clear_v_o,
   output logic [reg_addr_width_p-1:0]           clear_rd_o,
   output logic                                  empty_o
);

   localparam int ptr_w_lp = $clog2(fifo_els_p);
   localparam int cnt_w_lp = ptr_w_lp + 1;
   localparam int src_w_lp = (num_src_p > 1) ? $clog2(num_src_p) : 1;
   localparam logic [cnt_w_lp-1:0] full_cnt_lp = cnt_w_lp'(fifo_els_p);
   localparam logic [src_w_lp-1:0] last_src_lp = src_w_lp'(num_src_p - 1);

   typedef struct packed {
      logic [reg_addr_width_p-1:0] rd;
      logic [data_width_p-1:0]     data;
   } entry_t;

   entry_t                mem_q [fifo_els_p];
   logic [ptr_w_lp-1:0]   rd_ptr_q, rd_ptr_d;
   logic [ptr_w_lp-1:0]   wr_ptr_q, wr_ptr_d;
   logic [cnt_w_lp-1:0]   count_q, count_d;
   logic [src_w_lp-1:0]   rr_q, rr_d;
   logic [src_w_lp-1:0]   winner, idx;
   logic                  grant_v, enq, deq;
   entry_t                sel_entry;

   // Scan from the highest search offset down so the first valid source in
   // rr order is the last one written. Reset gates the grant so yumi drops
   // immediately on assertion, not at the next edge.
   always_comb begin
      grant_v = 1'b0;
      winner  = rr_q;
      idx     = rr_q;
      if (reset_n_i && (count_q < full_cnt_lp)) begin
         for (int k = num_src_p - 1; k >= 0; k--) begin
            idx = src_w_lp'((int'(rr_q) + k) % num_src_p);
            if (src_v_i[idx]) begin
               grant_v = 1'b1;
               winner  = idx;
            end
         end
      end
   end

   always_comb begin
      src_yumi_o = '0;
      if (grant_v) src_yumi_o[winner] = 1'b1;
   end

   assign sel_entry.rd   = src_rd_i[winner*reg_addr_width_p +: reg_addr_width_p];
   assign sel_entry.data = src_data_i[winner*data_width_p +: data_width_p];

   // Writes to x0 are consumed but never reach the RF or the scoreboard.
   assign enq = grant_v && (sel_entry.rd != '0);

   assign wb_v_o     = (count_q != '0);
   assign empty_o    = ~wb_v_o;
   assign wb_rd_o    = mem_q[rd_ptr_q].rd;
   assign wb_data_o  = mem_q[rd_ptr_q].data;
   assign deq        = wb_v_o && wb_ready_and_i;
   assign clear_v_o  = deq;
   assign clear_rd_o = wb_rd_o;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      rr_d     = rr_q;
      if (deq) rd_ptr_d = rd_ptr_q + ptr_w_lp'(1);
      if (enq) wr_ptr_d = wr_ptr_q + ptr_w_lp'(1);
      case ({enq, deq})
         2'b10:   count_d = count_q + cnt_w_lp'(1);
         2'b01:   count_d = count_q - cnt_w_lp'(1);
         default: count_d = count_q;
      endcase
      if (grant_v) rr_d = (winner == last_src_lp) ? '0 : winner + src_w_lp'(1);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         rr_q     <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         rr_q     <= rr_d;
      end
   end

   // NOTE: entry storage is not reset; count gates visibility, so stale contents never escape.
   always_ff @(posedge clk_i) begin
      if (enq) mem_q[wr_ptr_q] <= sel_entry;
   end

endmodule

// File: tb/tb_bp_be_late_wb_arbiter.sv
// Randomized self-checking bench for bp_be_late_wb_arbiter against a queue-based reference model.
module tb_bp_be_late_wb_arbiter;

   localparam int N     = 2;
   localparam int DW    = 64;
   localparam int AW    = 5;
   localparam int DEPTH = 4;

   typedef struct {
      logic [AW-1:0] rd;
      logic [DW-1:0] data;
   } wb_t;

   logic                clk_i = 1'b0;
   logic                reset_n_i;
   logic [N-1:0]        src_v_i;
   logic [N*AW-1:0]     src_rd_i;
   logic [N*DW-1:0]     src_data_i;
   logic [N-1:0]        src_yumi_o;
   logic                wb_v_o;
   logic [AW-1:0]       wb_rd_o;
   logic [DW-1:0]       wb_data_o;
   logic                wb_ready_and_i;
   logic                clear_v_o;
   logic [AW-1:0]       clear_rd_o;
   logic                empty_o;

   bp_be_late_wb_arbiter #(
      .num_src_p(N), .data_width_p(DW), .reg_addr_width_p(AW), .fifo_els_p(DEPTH)
   ) dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i),
      .src_v_i(src_v_i), .src_rd_i(src_rd_i), .src_data_i(src_data_i),
      .src_yumi_o(src_yumi_o),
      .wb_v_o(wb_v_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
      .wb_ready_and_i(wb_ready_and_i),
      .clear_v_o(clear_v_o), .clear_rd_o(clear_rd_o), .empty_o(empty_o)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;

   // Producer side: each source holds its offer until it sees its yumi.
   bit            p_v    [N];
   logic [AW-1:0] p_rd   [N];
   logic [DW-1:0] p_data [N];

   // Reference model: in-flight writebacks in arrival order plus the next source to favour.
   wb_t mq [$];
   int  rr = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic offer(input int s, input logic [AW-1:0] rd, input logic [DW-1:0] data);
      p_v[s]    = 1'b1;
      p_rd[s]   = rd;
      p_data[s] = data;
   endtask

   task automatic drive(input bit rdy);
      for (int s = 0; s < N; s++) begin
         src_v_i[s]              = p_v[s];
         src_rd_i[s*AW +: AW]    = p_rd[s];
         src_data_i[s*DW +: DW]  = p_data[s];
      end
      wb_ready_and_i = rdy;
   endtask

   // One clock: called at a negedge, checks outputs mid-low-phase, updates the model at posedge.
   task automatic step(input bit rdy);
      bit            gnt;
      int            win;
      logic [63:0]   exp_yumi;
      drive(rdy);
      #1;
      gnt = 1'b0;
      win = 0;
      if (mq.size() < DEPTH) begin
         for (int k = 0; k < N; k++) begin
            int s;
            s = (rr + k) % N;
            if (!gnt && p_v[s]) begin
               gnt = 1'b1;
               win = s;
            end
         end
      end
      exp_yumi = gnt ? (64'd1 << win) : 64'd0;
      check("yumi", 64'(src_yumi_o), exp_yumi);
      check("wb_v", 64'(wb_v_o), 64'(mq.size() != 0));
      check("empty", 64'(empty_o), 64'(mq.size() == 0));
      check("clear_v", 64'(clear_v_o), 64'((mq.size() != 0) && rdy));
      if (mq.size() != 0) begin
         check("wb_rd", 64'(wb_rd_o), 64'(mq[0].rd));
         check("wb_data", 64'(wb_data_o), 64'(mq[0].data));
         check("clear_rd", 64'(clear_rd_o), 64'(mq[0].rd));
      end
      @(posedge clk_i);
      if ((mq.size() != 0) && rdy) void'(mq.pop_front());
      if (gnt) begin
         if (p_rd[win] != '0) mq.push_back('{rd: p_rd[win], data: p_data[win]});
         p_v[win] = 1'b0;
         rr = (win + 1) % N;
      end
      @(negedge clk_i);
   endtask

   // Asynchronous reset pulse in the middle of the low phase with pending offers and ready high.
   task automatic pulse_reset();
      drive(1'b1);
      #2;
      reset_n_i = 1'b0;
      #1;
      check("rst_yumi", 64'(src_yumi_o), 64'd0);
      check("rst_wb_v", 64'(wb_v_o), 64'd0);
      check("rst_clear_v", 64'(clear_v_o), 64'd0);
      check("rst_empty", 64'(empty_o), 64'd1);
      mq.delete();
      rr = 0;
      @(negedge clk_i);
      reset_n_i = 1'b1;
   endtask

   initial begin
      int n_off;
      for (int s = 0; s < N; s++) begin
         p_v[s]    = 1'b1;
         p_rd[s]   = AW'(s + 1);
         p_data[s] = DW'(s);
      end
      reset_n_i = 1'b0;
      drive(1'b1);
      #3;
      check("init_yumi", 64'(src_yumi_o), 64'd0);
      check("init_wb_v", 64'(wb_v_o), 64'd0);
      check("init_clear_v", 64'(clear_v_o), 64'd0);
      check("init_empty", 64'(empty_o), 64'd1);
      for (int s = 0; s < N; s++) p_v[s] = 1'b0;
      @(negedge clk_i);
      reset_n_i = 1'b1;

      // Single source into an empty FIFO.
      offer(0, 5'd5, 64'hAA);
      repeat (3) step(1'b1);

      // Round-robin between two persistent sources.
      pulse_reset();
      for (int i = 0; i < 4; i++) begin
         if (!p_v[0]) offer(0, 5'd3, 64'h300 + 64'(i));
         if (!p_v[1]) offer(1, 5'd7, 64'h700 + 64'(i));
         step(1'b1);
      end
      for (int s = 0; s < N; s++) p_v[s] = 1'b0;
      repeat (3) step(1'b1);

      // Fill with backpressure, fifth offer waits for space.
      offer(0, 5'd10, 64'h10);
      offer(1, 5'd11, 64'h11);
      n_off = 2;
      for (int i = 0; i < 6; i++) begin
         step(1'b0);
         for (int s = 0; s < N; s++) begin
            if (!p_v[s] && n_off < 5) begin
               offer(s, AW'(10 + n_off), DW'(n_off));
               n_off++;
            end
         end
      end
      repeat (7) step(1'b1);

      // x0 writeback is consumed but never queued.
      offer(0, 5'd0, 64'h55);
      repeat (2) step(1'b1);

      // Back-to-back traffic across several pointer wraps.
      for (int i = 0; i < 10; i++) begin
         offer(1, AW'(i + 1), 64'hC000 + 64'(i));
         step(1'b1);
      end
      step(1'b1);

      // Mid-operation reset with entries queued; source 0 must win first afterwards.
      for (int i = 0; i < 3; i++) begin
         offer(0, AW'(20 + i), 64'hD0 + 64'(i));
         step(1'b0);
      end
      offer(0, 5'd30, 64'hE0);
      offer(1, 5'd31, 64'hE1);
      pulse_reset();
      repeat (3) step(1'b1);

      // Random traffic.
      for (int c = 0; c < 400; c++) begin
         for (int s = 0; s < N; s++) begin
            if (!p_v[s] && $urandom_range(0, 99) < 60) begin
               offer(s, ($urandom_range(0, 9) == 0) ? AW'(0) : AW'($urandom_range(1, 31)),
                     {$urandom, $urandom});
            end
         end
         step($urandom_range(0, 99) < 65);
      end
      for (int s = 0; s < N; s++) p_v[s] = 1'b0;
      repeat (DEPTH + 1) step(1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
